// File: rtl/spi_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_ram_pkg
// Description : Shared definitions for the SPI-attached command-decoded RAM.
//               The two-bit opcode sits in rx_data[DATA_W+1:DATA_W]; the
//               enumeration members double as the opcode constants.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_ram_pkg;

    typedef enum logic [1:0] {
        OP_SET_WADDR = 2'b00,
        OP_WRITE     = 2'b01,
        OP_SET_RADDR = 2'b10,
        OP_READ      = 2'b11
    } opcode_e;

endpackage : spi_ram_pkg
`default_nettype wire

// File: rtl/spi_ram_mem.sv
`default_nettype none
// ============================================================================
// Module      : spi_ram_mem
// Description : Simple dual-port synchronous RAM. It has one write port and
//               one registered read port. The read register loads only when
//               re is high, so rdata holds its last value between reads. The
//               array has no reset.
// Ports       : clk           clock
//               we/waddr/wdata write port
//               re/raddr      read request; the word is on rdata after the edge
//               rdata         registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module spi_ram_mem #(
    parameter int DATA_W    = 8,
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_W    = $clog2(MEM_DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [MEM_DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
        if (re) begin
            r_rdata <= r_mem[raddr];
        end
    end

    assign rdata = r_rdata;

endmodule : spi_ram_mem
`default_nettype wire

// File: rtl/spi_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : spi_ram_ctrl
// Description : Command-decoded RAM slave for an SPI front end. It decodes
//               opcode+payload words, keeps separate write and read pointers,
//               and returns read data over a valid/ready handshake. It also
//               raises a sticky error flag for out-of-range addresses and for
//               READs dropped while the tx slot is occupied.
//               Build option: define SPI_RAM_AUTO_INC_EN to make the pointers
//               post-increment on WRITE and on each accepted READ. The
//               pointers wrap from MEM_DEPTH-1 to 0.
// Ports       : clk, rst_n (async, active-low)
//               rx_data [DATA_W+1:0] opcode in the top two bits, payload below
//               rx_valid            one command per asserted cycle
//               tx_data/tx_valid    read data, held until tx_ready
//               tx_ready            transmitter accept
//               err                 sticky error, cleared only by reset
// Revision    : 1.0 - initial release
// ============================================================================
module spi_ram_ctrl
    import spi_ram_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_W    = $clog2(MEM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W+1:0] rx_data,
    input  logic              rx_valid,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              err
);

    if (ADDR_W > DATA_W) begin : g_addr_w_check
        $error("spi_ram_ctrl: ADDR_W (%0d) must not exceed DATA_W (%0d)", ADDR_W, DATA_W);
    end

    // One extra bit so that MEM_DEPTH == 2**DATA_W is still representable.
    localparam logic [DATA_W:0] c_depth = (DATA_W+1)'(MEM_DEPTH);

    opcode_e           w_op;
    logic [DATA_W-1:0] w_payload;
    logic              w_in_range;
    logic              w_set_waddr;
    logic              w_set_raddr;
    logic              w_write;
    logic              w_read_cmd;
    logic              w_slot_free;
    logic              w_read_acc;
    logic [DATA_W-1:0] w_rdata;

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic              r_tx_valid;
    logic              r_tx_loaded;
    logic              r_err;

    assign w_op        = opcode_e'(rx_data[DATA_W+1:DATA_W]);
    assign w_payload   = rx_data[DATA_W-1:0];
    assign w_in_range  = {1'b0, w_payload} < c_depth;
    assign w_set_waddr = rx_valid && (w_op == OP_SET_WADDR);
    assign w_set_raddr = rx_valid && (w_op == OP_SET_RADDR);
    assign w_write     = rx_valid && (w_op == OP_WRITE);
    assign w_read_cmd  = rx_valid && (w_op == OP_READ);
    // The slot is free when it is empty or is being emptied this very cycle.
    // This gives one word per cycle when reads come back to back.
    assign w_slot_free = !r_tx_valid || tx_ready;
    assign w_read_acc  = w_read_cmd && w_slot_free;

`ifdef SPI_RAM_AUTO_INC_EN
    localparam logic [ADDR_W-1:0] c_last = ADDR_W'(MEM_DEPTH - 1);

    // An explicit compare is needed because MEM_DEPTH may not be a power of two.
    function automatic logic [ADDR_W-1:0] f_ptr_inc(input logic [ADDR_W-1:0] ptr);
        return (ptr == c_last) ? '0 : ptr + 1'b1;
    endfunction
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_tx_valid  <= 1'b0;
            r_tx_loaded <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (w_set_waddr) begin
                if (w_in_range) r_wr_ptr <= w_payload[ADDR_W-1:0];
                else            r_err    <= 1'b1;
            end
`ifdef SPI_RAM_AUTO_INC_EN
            if (w_write) r_wr_ptr <= f_ptr_inc(r_wr_ptr);
`endif

            if (w_set_raddr) begin
                if (w_in_range) r_rd_ptr <= w_payload[ADDR_W-1:0];
                else            r_err    <= 1'b1;
            end
`ifdef SPI_RAM_AUTO_INC_EN
            if (w_read_acc) r_rd_ptr <= f_ptr_inc(r_rd_ptr);
`endif

            if (w_read_cmd && !w_slot_free) begin
                r_err <= 1'b1;
            end

            if (w_read_acc) begin
                r_tx_valid  <= 1'b1;
                r_tx_loaded <= 1'b1;
            end else if (r_tx_valid && tx_ready) begin
                r_tx_valid  <= 1'b0;
            end
        end
    end

    spi_ram_mem #(
        .DATA_W    (DATA_W),
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_W    (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (w_write),
        .waddr (r_wr_ptr),
        .wdata (w_payload),
        .re    (w_read_acc),
        .raddr (r_rd_ptr),
        .rdata (w_rdata)
    );

    // The RAM read register has no reset. The tx word is therefore gated to
    // zero until a READ has loaded it since the last reset. This also makes
    // tx_data drop to 0 as soon as rst_n is asserted.
    assign tx_data  = r_tx_loaded ? w_rdata : '0;
    assign tx_valid = r_tx_valid;
    assign err      = r_err;

endmodule : spi_ram_ctrl
`default_nettype wire

// File: tb/tb_spi_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_ram_ctrl
// Description : Self-checking bench for spi_ram_ctrl with DATA_W=8 and
//               MEM_DEPTH=200. A behavioural model of memory, pointers, tx
//               slot and error flag is compared against the DUT on every
//               falling clock edge. Directed sequences add literal
//               expectations. The bench follows SPI_RAM_AUTO_INC_EN when it
//               is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_ram_ctrl;
    import spi_ram_pkg::*;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 200;

    logic              clk      = 1'b0;
    logic              rst_n    = 1'b0;
    logic [DATA_W+1:0] rx_data  = '0;
    logic              rx_valid = 1'b0;
    logic              tx_ready = 1'b0;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              err;

    int n_checks = 0;
    int n_errors = 0;

    spi_ram_ctrl #(
        .DATA_W    (DATA_W),
        .MEM_DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] m_mem [DEPTH];
    int         m_wr  = 0;
    int         m_rd  = 0;
    bit         m_txv = 0;
    bit         m_err = 0;
    logic [7:0] m_txd = 8'h00;

    task automatic model_step();
        bit         acc;
        int         op;
        int         pl;
        acc = 0;
        op  = int'(rx_data[9:8]);
        pl  = int'(rx_data[7:0]);
        if (rx_valid) begin
            case (op)
                0: if (pl >= DEPTH) m_err = 1; else m_wr = pl;
                1: begin
                    m_mem[m_wr] = rx_data[7:0];
`ifdef SPI_RAM_AUTO_INC_EN
                    m_wr = (m_wr + 1) % DEPTH;
`endif
                end
                2: if (pl >= DEPTH) m_err = 1; else m_rd = pl;
                default: begin
                    if (!m_txv || tx_ready) begin
                        acc   = 1;
                        m_txd = m_mem[m_rd];
`ifdef SPI_RAM_AUTO_INC_EN
                        m_rd = (m_rd + 1) % DEPTH;
`endif
                    end else begin
                        m_err = 1;
                    end
                end
            endcase
        end
        if (acc)           m_txv = 1;
        else if (tx_ready) m_txv = 0;
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_wr = 0; m_rd = 0; m_txv = 0; m_err = 0; m_txd = 8'h00;
            end else begin
                model_step();
            end
        end
    end

    // Compare the DUT against the model on every cycle out of reset.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                check("cmp_tx_valid", 32'(tx_valid), 32'(m_txv));
                check("cmp_tx_data",  32'(tx_data),  32'(m_txd));
                check("cmp_err",      32'(err),      32'(m_err));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit v, input logic [1:0] op, input logic [7:0] pl, input bit rdy);
        @(posedge clk);
        #1;
        rx_valid = v;
        rx_data  = {op, pl};
        tx_ready = rdy;
    endtask

    initial begin
        // Reset state.
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        check("reset_tx_valid", 32'(tx_valid), 32'h0);
        check("reset_tx_data",  32'(tx_data),  32'h0);
        check("reset_err",      32'(err),      32'h0);
        check("model_reset_v",  32'(m_txv),    32'h0);

        // Basic write/read with one cycle of latency.
        step(1, OP_SET_WADDR, 8'h10, 1);
        step(1, OP_WRITE,     8'hA5, 1);
        step(1, OP_SET_RADDR, 8'h10, 1);
        step(1, OP_READ,      8'h00, 1);
        @(negedge clk);
        check("t1_before_latency", 32'(tx_valid), 32'h0);
        step(0, OP_SET_WADDR, 8'h00, 1);
        @(negedge clk);
        check("t1_valid",  32'(tx_valid), 32'h1);
        check("t1_data",   32'(tx_data),  32'hA5);
        check("model_t1",  32'(m_txd),    32'hA5);
        step(0, OP_SET_WADDR, 8'h00, 1);
        @(negedge clk);
        check("t1_one_cycle", 32'(tx_valid), 32'h0);
        check("t1_data_hold", 32'(tx_data),  32'hA5);

        // Out-of-range SET_WADDR leaves the pointer unchanged.
        step(1, OP_SET_WADDR, 8'h30, 1);
        step(1, OP_SET_WADDR, 8'hC8, 1);
        step(0, OP_SET_WADDR, 8'h00, 1);
        @(negedge clk);
        check("t3_err", 32'(err), 32'h1);
        step(1, OP_WRITE,     8'h33, 1);
        step(1, OP_SET_RADDR, 8'h30, 1);
        step(1, OP_READ,      8'h00, 1);
        step(0, OP_SET_WADDR, 8'h00, 1);
        @(negedge clk);
        check("t3_data", 32'(tx_data), 32'h33);

        // Plain reset: err clears.
        @(posedge clk); #3 rst_n = 1'b0;
        #1 check("rst2_err", 32'(err), 32'h0);
        @(posedge clk); #3 rst_n = 1'b1;

        // Stall: tx_ready low holds the word, and a second READ is dropped.
        step(1, OP_SET_RADDR, 8'h10, 0);
        step(1, OP_READ,      8'h00, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, OP_SET_WADDR, 8'h00, 0);
            @(negedge clk);
            check("t2_stall_valid", 32'(tx_valid), 32'h1);
            check("t2_stall_data",  32'(tx_data),  32'hA5);
        end
        step(1, OP_READ, 8'h00, 0);
        step(0, OP_SET_WADDR, 8'h00, 0);
        @(negedge clk);
        check("t2_drop_err",  32'(err),     32'h1);
        check("t2_drop_data", 32'(tx_data), 32'hA5);
        step(0, OP_SET_WADDR, 8'h00, 1);
        step(0, OP_SET_WADDR, 8'h00, 1);
        @(negedge clk);
        check("t2_released", 32'(tx_valid), 32'h0);

        // Back-to-back READs.
        for (int i = 0; i < 4; i++) begin
            step(1, OP_SET_WADDR, 8'(8'h40 + i), 1);
            step(1, OP_WRITE,     8'(i + 1),     1);
        end
        step(1, OP_SET_RADDR, 8'h40, 1);
        for (int i = 0; i < 4; i++) begin
            step(1, OP_READ, 8'h00, 1);
            @(negedge clk);
            if (i > 0) begin
                check("t4_b2b_valid", 32'(tx_valid), 32'h1);
`ifdef SPI_RAM_AUTO_INC_EN
                check("t4_b2b_data", 32'(tx_data), 32'(i));
`else
                check("t4_b2b_data", 32'(tx_data), 32'h1);
`endif
            end
        end
        step(0, OP_SET_WADDR, 8'h00, 1);
        @(negedge clk);
        check("t4_last_valid", 32'(tx_valid), 32'h1);
`ifdef SPI_RAM_AUTO_INC_EN
        check("t4_last_data", 32'(tx_data), 32'h4);
`else
        check("t4_last_data", 32'(tx_data), 32'h1);
`endif
        step(0, OP_SET_WADDR, 8'h00, 1);
        @(negedge clk);
        check("t4_drain", 32'(tx_valid), 32'h0);

        // Top address and wrap-around.
`ifdef SPI_RAM_AUTO_INC_EN
        step(1, OP_SET_WADDR, 8'hC7, 1);
        step(1, OP_WRITE,     8'h11, 1);
        step(1, OP_WRITE,     8'h22, 1);
        step(1, OP_SET_RADDR, 8'hC7, 1);
        step(1, OP_READ,      8'h00, 1);
        step(1, OP_READ,      8'h00, 1);
        @(negedge clk);
        check("t5_wrap_first", 32'(tx_data), 32'h11);
        step(0, OP_SET_WADDR, 8'h00, 1);
        @(negedge clk);
        check("t5_wrap_valid",  32'(tx_valid), 32'h1);
        check("t5_wrap_second", 32'(tx_data),  32'h22);
`else
        step(1, OP_SET_WADDR, 8'hC7, 1);
        step(1, OP_WRITE,     8'h11, 1);
        step(1, OP_SET_RADDR, 8'hC7, 1);
        step(1, OP_READ,      8'h00, 1);
        step(0, OP_SET_WADDR, 8'h00, 1);
        @(negedge clk);
        check("t5_top_addr", 32'(tx_data), 32'h11);
`endif

        // Reset while tx_valid is high; memory survives.
        step(1, OP_SET_RADDR, 8'h10, 0);
        step(1, OP_READ,      8'h00, 0);
        step(0, OP_SET_WADDR, 8'h00, 0);
        @(negedge clk);
        check("t6_pre_valid", 32'(tx_valid), 32'h1);
        check("t6_pre_err",   32'(err),      32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(tx_valid), 32'h0);
        check("t6_rst_data",  32'(tx_data),  32'h0);
        check("t6_rst_err",   32'(err),      32'h0);
        @(posedge clk); #3 rst_n = 1'b1;
        step(1, OP_SET_RADDR, 8'hC7, 1);
        step(1, OP_READ,      8'h00, 1);
        step(0, OP_SET_WADDR, 8'h00, 1);
        @(negedge clk);
        check("t6_retained", 32'(tx_data), 32'h11);
        step(1, OP_SET_RADDR, 8'h10, 1);
        step(1, OP_READ,      8'h00, 1);
        step(0, OP_SET_WADDR, 8'h00, 1);
        @(negedge clk);
        check("t6_retained_a5", 32'(tx_data), 32'hA5);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_spi_ram_ctrl
`default_nettype wire
